// File: rtl/ej32_div_seq.sv
// ej32_div_seq: sequential signed 32-bit divider for idiv/irem.
// Restoring radix-2 on magnitudes, one quotient bit per RUN cycle,
// then sign fix-up to Java semantics (truncate toward zero).
// Ports:
//   clk  in       clock, all state changes on posedge
//   rst  in       sync active-high reset (held by DP while idle)
//   x    in  DSZ  dividend (NOS), sampled in LOAD only
//   y    in  DSZ  divisor (TOS), sampled in LOAD only
//   bsy  out      high until q/r/z are valid
//   z    out      divide-by-zero seen in LOAD
//   q    out DSZ  quotient
//   r    out DSZ  remainder, sign of dividend
module ej32_div_seq #(
   parameter int DSZ   = 32,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [DSZ-1:0] x,
   input  logic [DSZ-1:0] y,
   output logic           bsy,
   output logic           z,
   output logic [DSZ-1:0] q,
   output logic [DSZ-1:0] r
);

   typedef enum logic [1:0] {
      S_LOAD,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bsy_q, bsy_d;
   logic             z_q, z_d;
   logic [DSZ-1:0]   q_q, q_d;
   logic [DSZ-1:0]   r_q, r_d;

   logic [DSZ-1:0]   rem_q, rem_d;
   logic [DSZ-1:0]   quo_q, quo_d;
   logic [DSZ-1:0]   ay_q, ay_d;
   logic             sx_q, sx_d;
   logic             sy_q, sy_d;

   logic [DSZ-1:0]   rem_sh;
   logic [DSZ:0]     trial;

   // Remainder stays below ay <= 2^(DSZ-1), so the shifted value
   // fits in DSZ bits; the extra trial bit is the borrow.
   assign rem_sh = {rem_q[DSZ-2:0], quo_q[DSZ-1]};
   assign trial  = {1'b0, rem_sh} - {1'b0, ay_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bsy_d   = bsy_q;
      z_d     = z_q;
      q_d     = q_q;
      r_d     = r_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      ay_d    = ay_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      unique case (state_q)
         S_LOAD: begin
            sx_d = x[DSZ-1];
            sy_d = y[DSZ-1];
            // Negating MIN wraps back to MIN, which is the
            // correct unsigned magnitude.
            ay_d = y[DSZ-1] ? -y : y;
            if (y == '0) begin
               z_d     = 1'b1;
               q_d     = '0;
               r_d     = x;
               bsy_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               rem_d   = '0;
               quo_d   = x[DSZ-1] ? -x : x;
               cnt_d   = CNT_W'(DSZ);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            rem_d = trial[DSZ] ? rem_sh : trial[DSZ-1:0];
            quo_d = {quo_q[DSZ-2:0], ~trial[DSZ]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            q_d     = (sx_q ^ sy_q) ? -quo_q : quo_q;
            r_d     = sx_q ? -rem_q : rem_q;
            bsy_d   = 1'b0;
            state_d = S_DONE;
         end
         S_DONE: begin
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOAD;
         cnt_q   <= '0;
         bsy_q   <= 1'b1;
         z_q     <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bsy_q   <= bsy_d;
         z_q     <= z_d;
         q_q     <= q_d;
         r_q     <= r_d;
      end
   end

   // Datapath scratch registers are always rewritten in LOAD
   // before use, so they carry no reset.
   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      ay_q  <= ay_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
   end

   assign bsy = bsy_q;
   assign z   = z_q;
   assign q   = q_q;
   assign r   = r_q;

endmodule

// File: tb/tb_ej32_div_seq.sv
// tb_ej32_div_seq: scoreboard bench for ej32_div_seq.
// Expected q/r/z/latency queued at drive time, popped at !bsy.
module tb_ej32_div_seq;

   localparam int DSZ = 32;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic [31:0] z;
      logic [31:0] lat;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DSZ-1:0]  x = '0;
   logic [DSZ-1:0]  y = '0;
   logic            bsy;
   logic            z;
   logic [DSZ-1:0]  q;
   logic [DSZ-1:0]  r;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ej32_div_seq #(.DSZ(DSZ), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .x   (x),
      .y   (y),
      .bsy (bsy),
      .z   (z),
      .q   (q),
      .r   (r)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t model(input logic [31:0] xv,
                                  input logic [31:0] yv);
      exp_t e;
      logic signed [31:0] xs, ys;
      xs = xv;
      ys = yv;
      if (yv == 32'd0) begin
         e.q = 0; e.r = xv; e.z = 1; e.lat = 1;
      end else if (xv == 32'h8000_0000 && yv == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000; e.r = 0; e.z = 0; e.lat = 34;
      end else begin
         e.q = xs / ys; e.r = xs % ys; e.z = 0; e.lat = 34;
      end
      return e;
   endfunction

   task automatic go_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Release reset with operands; optionally scramble x/y while busy.
   task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                         input bit scramble, input string tag);
      exp_t e;
      int   n;
      sb.push_back(model(xv, yv));
      x   = xv;
      y   = yv;
      rst = 1'b0;
      n   = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (!bsy) break;
         if (scramble) begin
            x = $urandom;
            y = $urandom;
         end
      end
      e = sb.pop_front();
      check({tag, ".lat"}, n, e.lat);
      check({tag, ".q"}, q, e.q);
      check({tag, ".r"}, r, e.r);
      check({tag, ".z"}, {31'd0, z}, e.z);
   endtask

   initial begin
      logic [31:0] hq, hr;
      logic [31:0] rx, ry;

      repeat (3) @(posedge clk);
      #1;
      check("rst.bsy", {31'd0, bsy}, 1);
      check("rst.z", {31'd0, z}, 0);
      check("rst.q", q, 0);
      check("rst.r", r, 0);

      @(negedge clk);
      run_op(100, 7, 0, "p_p");
      go_reset();
      run_op(-100, 7, 0, "n_p");
      go_reset();
      run_op(100, -7, 0, "p_n");
      go_reset();
      run_op(-100, -7, 0, "n_n");
      go_reset();
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, "ovf");
      go_reset();
      run_op(32'h8000_0000, 1, 0, "min1");
      go_reset();
      run_op(7, 32'h8000_0000, 0, "divmin");
      go_reset();

      run_op(5, 0, 0, "dz");
      hq = q;
      hr = r;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         x = $urandom;
         y = $urandom;
         @(posedge clk);
         #1;
         check("dz.hold.bsy", {31'd0, bsy}, 0);
         check("dz.hold.z", {31'd0, z}, 1);
         check("dz.hold.q", q, 0);
         check("dz.hold.r", r, 5);
      end
      go_reset();

      // Abort mid-RUN, then a fresh operation.
      x   = 1000;
      y   = 3;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort.bsy", {31'd0, bsy}, 1);
      check("abort.q", q, 0);
      check("abort.r", r, 0);
      check("abort.z", {31'd0, z}, 0);
      @(negedge clk);
      run_op(9, 4, 0, "post_abort");
      go_reset();

      run_op(1000, 3, 1, "scramble");
      go_reset();

      for (int i = 0; i < 1200; i++) begin
         rx = $urandom;
         ry = $urandom;
         case (i % 4)
            1: ry = $urandom_range(1, 20);
            2: ry = -$urandom_range(1, 20);
            3: rx = $urandom_range(0, 1000);
            default: ;
         endcase
         if (ry == 0) ry = 1;
         run_op(rx, ry, 0, "rand");
         go_reset();
      end

      check("sb.empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
